// File: rtl/alloc_if.sv
// Allocator-facing bus of alloc_driver: alloc/free strobes, data/address and error.
// Signal names follow the driver's point of view (o_* driven by the driver).
interface alloc_if;
    logic        o_alloc;
    logic [15:0] o_data;
    logic [15:0] i_addr;
    logic        o_free;
    logic [15:0] o_addr;
    logic        i_err;

    modport master (output o_alloc, o_data, o_free, o_addr, input i_addr, i_err);
    modport slave  (input o_alloc, o_data, o_free, o_addr, output i_addr, i_err);
endinterface

// File: rtl/alloc_driver.sv
// Allocator exerciser: issues N_REQ allocations, checks every returned address for
// UNDEF and duplicates, frees them in LIFO order, then reports pass/fail.
module alloc_driver #(
    parameter int          N_REQ     = 8,
    parameter int          STK_LOG   = 4,
    parameter int          GAP       = 4,
    parameter int          ALLOC_LAT = 1,
    parameter logic [15:0] DATA_SEED = 16'h0001
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    output logic         o_busy,
    output logic         o_pass,
    output logic         o_fail,
    output logic [2:0]   o_code,
    alloc_if.master      bus
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ALLOC = 4'd1;
    localparam logic [3:0] S_WAIT  = 4'd2;
    localparam logic [3:0] S_CHECK = 4'd3;
    localparam logic [3:0] S_PUSH  = 4'd4;
    localparam logic [3:0] S_AGAP  = 4'd5;
    localparam logic [3:0] S_FREE  = 4'd6;
    localparam logic [3:0] S_FGAP  = 4'd7;
    localparam logic [3:0] S_PASS  = 4'd8;
    localparam logic [3:0] S_FAIL  = 4'd9;

    localparam int               DEPTH   = 1 << STK_LOG;
    localparam logic [STK_LOG:0] ONE     = (STK_LOG+1)'(1);
    localparam logic [STK_LOG:0] N_REQ_W = (STK_LOG+1)'(N_REQ);
    localparam logic [15:0]      LAT_W   = 16'(ALLOC_LAT);
    localparam logic [15:0]      GAP_W   = 16'(GAP);

    logic [3:0]         r_state;
    logic [STK_LOG:0]   r_sp;
    logic [STK_LOG:0]   r_k;
    logic [STK_LOG:0]   r_j;
    logic [15:0]        r_cnt;
    logic [15:0]        r_cap;
    logic [15:0]        r_stack [DEPTH];
    logic               r_busy;
    logic               r_alloc;
    logic               r_free;
    logic               r_pass;
    logic               r_fail;
    logic [2:0]         r_code;
    logic [15:0]        r_data;
    logic [15:0]        r_addr;

    logic [STK_LOG:0]   w_dec;
    logic [STK_LOG-1:0] w_top;
    logic [STK_LOG-1:0] w_scan;

    assign w_dec  = r_sp - ONE;
    assign w_top  = w_dec[STK_LOG-1:0];
    assign w_scan = r_j[STK_LOG-1:0];

    // Sequencer: a high i_err during a run overrides whatever the state would do
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_sp    <= '0;
            r_k     <= '0;
            r_j     <= '0;
            r_cnt   <= 16'h0000;
            r_cap   <= 16'h0000;
            r_busy  <= 1'b0;
            r_alloc <= 1'b0;
            r_free  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_code  <= 3'd0;
            r_data  <= 16'h0000;
            r_addr  <= 16'h0000;
        end else begin
            r_alloc <= 1'b0;
            r_free  <= 1'b0;
            if (r_busy && bus.i_err) begin
                r_state <= S_FAIL;
                r_busy  <= 1'b0;
                r_fail  <= 1'b1;
                r_code  <= 3'd3;
            end else begin
                case (r_state)
                    S_IDLE, S_PASS, S_FAIL: begin
                        if (i_start) begin
                            r_pass  <= 1'b0;
                            r_fail  <= 1'b0;
                            r_code  <= 3'd0;
                            r_sp    <= '0;
                            r_k     <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_ALLOC;
                        end
                    end
                    S_ALLOC: begin
                        r_alloc <= 1'b1;
                        r_data  <= DATA_SEED + 16'(r_k);
                        r_cnt   <= LAT_W;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (r_cnt == 16'h0000) begin
                            if (bus.i_addr == 16'h0000) begin
                                r_state <= S_FAIL;
                                r_busy  <= 1'b0;
                                r_fail  <= 1'b1;
                                r_code  <= 3'd1;
                            end else begin
                                r_cap   <= bus.i_addr;
                                r_j     <= '0;
                                r_state <= S_CHECK;
                            end
                        end else begin
                            r_cnt <= r_cnt - 16'h0001;
                        end
                    end
                    S_CHECK: begin
                        if (r_j == r_sp) begin
                            r_state <= S_PUSH;
                        end else if (r_stack[w_scan] == r_cap) begin
                            r_state <= S_FAIL;
                            r_busy  <= 1'b0;
                            r_fail  <= 1'b1;
                            r_code  <= 3'd2;
                        end else begin
                            r_j <= r_j + ONE;
                        end
                    end
                    S_PUSH: begin
                        r_sp    <= r_sp + ONE;
                        r_k     <= r_k + ONE;
                        r_cnt   <= GAP_W;
                        r_state <= S_AGAP;
                    end
                    S_AGAP: begin
                        if (r_cnt == 16'h0001) begin
                            r_state <= (r_k == N_REQ_W) ? S_FREE : S_ALLOC;
                        end else begin
                            r_cnt <= r_cnt - 16'h0001;
                        end
                    end
                    S_FREE: begin
                        r_free  <= 1'b1;
                        r_addr  <= r_stack[w_top];
                        r_sp    <= w_dec;
                        r_cnt   <= GAP_W;
                        r_state <= S_FGAP;
                    end
                    S_FGAP: begin
                        if (r_cnt == 16'h0001) begin
                            if (r_sp == '0) begin
                                r_state <= S_PASS;
                                r_busy  <= 1'b0;
                                r_pass  <= 1'b1;
                            end else begin
                                r_state <= S_FREE;
                            end
                        end else begin
                            r_cnt <= r_cnt - 16'h0001;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Address stack: contents are don't-care after reset, only entries below sp are read
    always_ff @(posedge i_clk) begin
        if (!i_rst && r_state == S_PUSH) begin
            r_stack[r_sp[STK_LOG-1:0]] <= r_cap;
        end
    end

    assign o_busy      = r_busy;
    assign o_pass      = r_pass;
    assign o_fail      = r_fail;
    assign o_code      = r_code;
    assign bus.o_alloc = r_alloc;
    assign bus.o_data  = r_data;
    assign bus.o_free  = r_free;
    assign bus.o_addr  = r_addr;
endmodule

// File: tb/tb_alloc_driver.sv
// Bench for alloc_driver: directed scenarios plus random address runs, each compared
// against a rule-level model of what the run should produce.
module tb_alloc_driver;
    localparam int          N_REQ     = 8;
    localparam int          GAP       = 4;
    localparam logic [15:0] DATA_SEED = 16'h0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, pass, fail;
    logic [2:0] code;

    alloc_if bus ();

    alloc_driver dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .o_busy (busy),
        .o_pass (pass),
        .o_fail (fail),
        .o_code (code),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] ret_addr [N_REQ];
    int          err_after_free;
    logic [15:0] q_data [$];
    logic [15:0] q_free [$];
    int          gap_bad, overlap, timed_out, extra;

    int          exp_allocs, exp_code;
    logic [15:0] exp_free [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string t);
        chk({t, "_busy"},  32'(busy), 32'd0);
        chk({t, "_pass"},  32'(pass), 32'd0);
        chk({t, "_fail"},  32'(fail), 32'd0);
        chk({t, "_code"},  32'(code), 32'd0);
        chk({t, "_alloc"}, 32'(bus.o_alloc), 32'd0);
        chk({t, "_free"},  32'(bus.o_free), 32'd0);
        chk({t, "_data"},  32'(bus.o_data), 32'd0);
        chk({t, "_addr"},  32'(bus.o_addr), 32'd0);
    endtask

    task automatic set_clean(input logic [15:0] base);
        for (int i = 0; i < N_REQ; i++) ret_addr[i] = base + 16'(i);
        err_after_free = 0;
    endtask

    // Expected outcome from the rules: allocations stop at the first bad address,
    // otherwise every address is freed newest-first unless i_err cuts that short.
    task automatic model();
        logic [15:0] seen [$];
        bit dup;
        seen.delete();
        exp_free.delete();
        exp_allocs = 0;
        exp_code = 0;
        for (int i = 0; i < N_REQ; i++) begin
            exp_allocs++;
            if (ret_addr[i] == 16'h0000) begin exp_code = 1; break; end
            dup = 1'b0;
            foreach (seen[s]) if (seen[s] == ret_addr[i]) dup = 1'b1;
            if (dup) begin exp_code = 2; break; end
            seen.push_back(ret_addr[i]);
        end
        if (exp_code == 0) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                exp_free.push_back(ret_addr[i]);
                if (exp_free.size() == err_after_free) begin exp_code = 3; break; end
            end
        end
    endtask

    // One run, observed once per cycle on the falling edge; abort_rst resets during the 5th WAIT.
    task automatic run_one(input string t, input int hold_start, input bit abort_rst);
        int cyc, nalloc, nfree, last_free;
        q_data.delete();
        q_free.delete();
        gap_bad = 0; overlap = 0; timed_out = 0; extra = 0;
        cyc = 0; nalloc = 0; nfree = 0; last_free = -1;
        start = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc >= hold_start) start = 1'b0;
            bus.i_err = 1'b0;
            if (cyc == 1) begin
                chk({t, "_start_busy"}, 32'(busy), 32'd1);
                chk({t, "_start_clr"}, {28'd0, pass, fail, code[1:0]}, 32'd0);
            end
            if (bus.o_alloc && bus.o_free) overlap++;
            if (bus.o_alloc) begin
                q_data.push_back(bus.o_data);
                bus.i_addr = ret_addr[nalloc % N_REQ];
                nalloc++;
                if (abort_rst && nalloc == 5) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk_zero_outputs({t, "_midrst"});
                    rst = 1'b0;
                    return;
                end
            end
            if (bus.o_free) begin
                q_free.push_back(bus.o_addr);
                if (last_free >= 0 && cyc - last_free != GAP + 1) gap_bad++;
                last_free = cyc;
                nfree++;
                if (nfree == err_after_free) bus.i_err = 1'b1;
            end
            if (pass || fail) break;
            if (cyc > 3000) begin timed_out = 1; break; end
        end
        bus.i_err = 1'b0;
        start = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_alloc || bus.o_free) extra++;
        end
    endtask

    task automatic compare(input string t);
        model();
        chk({t, "_timeout"}, 32'(timed_out), 32'd0);
        chk({t, "_nalloc"}, 32'(q_data.size()), 32'(exp_allocs));
        for (int i = 0; i < q_data.size() && i < exp_allocs; i++)
            chk($sformatf("%s_data%0d", t, i), 32'(q_data[i]), 32'(DATA_SEED + 16'(i)));
        chk({t, "_nfree"}, 32'(q_free.size()), 32'(exp_free.size()));
        for (int i = 0; i < q_free.size() && i < exp_free.size(); i++)
            chk($sformatf("%s_free%0d", t, i), 32'(q_free[i]), 32'(exp_free[i]));
        chk({t, "_pass"}, 32'(pass), 32'(exp_code == 0));
        chk({t, "_fail"}, 32'(fail), 32'(exp_code != 0));
        chk({t, "_code"}, 32'(code), 32'(exp_code));
        chk({t, "_busy"}, 32'(busy), 32'd0);
        chk({t, "_overlap"}, 32'(overlap), 32'd0);
        chk({t, "_freegap"}, 32'(gap_bad), 32'd0);
        chk({t, "_extra"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int mode, idx;
        rst = 1'b1;
        start = 1'b0;
        bus.i_addr = 16'h0000;
        bus.i_err = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        set_clean(16'h5000);
        run_one("clean", 1, 1'b0);
        compare("clean");

        set_clean(16'h5000);
        ret_addr[2] = 16'h0000;
        run_one("undef", 1, 1'b0);
        compare("undef");

        set_clean(16'h5000);
        ret_addr[3] = 16'h5001;
        run_one("dup", 1, 1'b0);
        compare("dup");

        set_clean(16'h5000);
        err_after_free = 2;
        run_one("err", 1, 1'b0);
        compare("err");

        set_clean(16'h5000);
        run_one("rst", 1, 1'b1);
        @(negedge clk);
        run_one("after_rst", 1, 1'b0);
        compare("after_rst");

        set_clean(16'h6000);
        run_one("hold", 60, 1'b0);
        compare("hold");
        run_one("rerun_pass", 1, 1'b0);
        compare("rerun_pass");
        ret_addr[5] = 16'h6001;
        run_one("to_fail", 1, 1'b0);
        compare("to_fail");
        set_clean(16'h6000);
        run_one("rerun_fail", 1, 1'b0);
        compare("rerun_fail");

        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N_REQ; i++) ret_addr[i] = 16'($urandom_range(1, 65535));
            err_after_free = 0;
            mode = $urandom_range(0, 3);
            idx = $urandom_range(1, N_REQ - 1);
            if (mode == 1) ret_addr[idx] = 16'h0000;
            if (mode == 2) ret_addr[idx] = ret_addr[$urandom_range(0, idx - 1)];
            if (mode == 3) err_after_free = $urandom_range(1, N_REQ);
            run_one($sformatf("rand%0d", it), 1, 1'b0);
            compare($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
